// File: rtl/pe_pkg.sv
// Shared definitions for the PE merge stage: source tags and the two-way
// round-robin pick used by the arbiter.
package pe_pkg;

    localparam logic SRC_L0 = 1'b0;
    localparam logic SRC_L1 = 1'b1;

    // One-hot grant: on contention the input that did not win last time goes first.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
        if (req == 2'b11) begin
            return (last_grant == SRC_L1) ? 2'b01 : 2'b10;
        end
        return req;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the fairness state only moves when the
// caller reports that the grant was actually used.
module rr_arb2
    import pe_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       last_grant
);

    logic r_last_grant;

    assign gnt        = rr_pick(req, r_last_grant);
    assign last_grant = r_last_grant;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= SRC_L1;
        end else if (advance) begin
            r_last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/pe_merge2.sv
// Two-input merge: round-robin arbitration into a small tagged output FIFO,
// each word carrying the index of the input it came from.
module pe_merge2
    import pe_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             l0_valid,
    input  logic [WIDTH-1:0] l0_data,
    output logic             l0_ready,
    input  logic             l1_valid,
    input  logic [WIDTH-1:0] l1_data,
    output logic             l1_ready,
    output logic             r_valid,
    output logic [WIDTH-1:0] r_data,
    output logic             r_src,
    input  logic             r_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             src;
        logic [WIDTH-1:0] data;
    } merge_entry_t;

    merge_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_gnt;
    logic         w_last_grant;
    merge_entry_t w_entry;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        ({l1_valid, l0_valid}),
        .advance    (w_push),
        .gnt        (w_gnt),
        .last_grant (w_last_grant)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        l0_ready     = 1'b0;
        l1_ready     = 1'b0;
        w_entry.src  = SRC_L0;
        w_entry.data = l0_data;
        if (rst_n && !w_full) begin
            l0_ready = w_gnt[0];
            l1_ready = w_gnt[1];
        end
        if (w_gnt[1]) begin
            w_entry.src  = SRC_L1;
            w_entry.data = l1_data;
        end
    end

    // Readies never look at r_ready: a full FIFO stalls even when it is being drained.
    assign w_push = (l0_valid && l0_ready) || (l1_valid && l1_ready);
    assign w_pop  = !w_empty && r_ready;

    // NOTE: storage is reset along with the pointers so the outputs read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign r_valid = !w_empty;
    assign r_data  = r_mem[r_rd_ptr].data;
    assign r_src   = r_mem[r_rd_ptr].src;

    // The fairness register must always record the source of the word just written.
    a_last_grant_tracks_push : assert property (
        @(posedge clk) disable iff (!rst_n)
        w_push |=> (w_last_grant == $past(w_entry.src))
    );

endmodule

// File: tb/tb_pe_merge2.sv
// Scoreboard bench for pe_merge2: a queue-based reference of the merge stage
// predicts readies and output words; a separate monitor checks every pop.
module tb_pe_merge2;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             l0_valid, l1_valid, r_ready;
    logic [WIDTH-1:0] l0_data, l1_data;
    logic             l0_ready, l1_ready, r_valid, r_src;
    logic [WIDTH-1:0] r_data;

    int checks = 0;
    int errors = 0;

    // Reference state: queued words (tag in MSB), occupancy, and last winner.
    logic [WIDTH:0] sb[$];
    int             m_cnt  = 0;
    logic           m_last = 1'b1;
    logic           acc0, acc1;

    pe_merge2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .l0_valid (l0_valid),
        .l0_data  (l0_data),
        .l0_ready (l0_ready),
        .l1_valid (l1_valid),
        .l1_data  (l1_data),
        .l1_ready (l1_ready),
        .r_valid  (r_valid),
        .r_data   (r_data),
        .r_src    (r_src),
        .r_ready  (r_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every word the consumer takes must match the oldest predicted word.
    always @(negedge clk) begin
        if (rst_n && r_valid && r_ready) begin
            if (sb.size() == 0) begin
                check("out_unexpected", 32'(r_valid), 32'd0);
            end else begin
                check("out_word", 32'({r_src, r_data}), 32'(sb[0]));
                void'(sb.pop_front());
            end
        end
    end

    // Drive one cycle, predict readies from the arbitration rules, log accepted words.
    task automatic step(input logic v0, input logic [WIDTH-1:0] d0,
                        input logic v1, input logic [WIDTH-1:0] d1, input logic rr);
        int   g;
        logic full, pop;
        l0_valid = v0; l0_data = d0;
        l1_valid = v1; l1_data = d1;
        r_ready  = rr;
        @(negedge clk);
        full = (m_cnt == DEPTH);
        g = -1;
        if (v0 && v1) g = m_last ? 0 : 1;
        else if (v0)  g = 0;
        else if (v1)  g = 1;
        acc0 = !full && (g == 0);
        acc1 = !full && (g == 1);
        check("l0_ready", 32'(l0_ready), 32'(acc0));
        check("l1_ready", 32'(l1_ready), 32'(acc1));
        check("r_valid", 32'(r_valid), 32'(m_cnt != 0));
        pop = rr && (m_cnt != 0);
        if (acc0 || acc1) begin
            sb.push_back(acc1 ? {1'b1, d1} : {1'b0, d0});
            m_last = acc1;
            m_cnt++;
        end
        if (pop) m_cnt--;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             p0, p1;
        logic [WIDTH-1:0] pd0, pd1;

        // Reset held with both producers offering.
        rst_n = 1'b0; r_ready = 1'b1;
        l0_valid = 1'b1; l0_data = 4'h3;
        l1_valid = 1'b1; l1_data = 4'h4;
        repeat (3) begin
            @(negedge clk);
            check("rst_l0_ready", 32'(l0_ready), 32'd0);
            check("rst_l1_ready", 32'(l1_ready), 32'd0);
            check("rst_r_valid", 32'(r_valid), 32'd0);
            check("rst_r_data", 32'({r_src, r_data}), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single source back-to-back.
        step(1'b1, 4'h3, 1'b0, '0, 1'b1);
        step(1'b1, 4'h5, 1'b0, '0, 1'b1);
        step(1'b1, 4'h9, 1'b0, '0, 1'b1);
        drain();

        // Contention: grants alternate starting from whoever did not win last.
        repeat (4) step(1'b1, 4'hA, 1'b1, 4'hB, 1'b1);
        drain();

        // Backpressure: third word from l1 must wait until a pop frees a slot.
        step(1'b0, '0, 1'b1, 4'h1, 1'b0);
        step(1'b0, '0, 1'b1, 4'h2, 1'b0);
        step(1'b0, '0, 1'b1, 4'h3, 1'b0);
        step(1'b0, '0, 1'b1, 4'h3, 1'b1);
        step(1'b0, '0, 1'b1, 4'h3, 1'b0);
        drain();

        // Full with simultaneous pop, then contention shows last_grant held.
        step(1'b0, '0, 1'b1, 4'h7, 1'b0);
        step(1'b0, '0, 1'b1, 4'h8, 1'b0);
        step(1'b1, 4'hC, 1'b0, '0, 1'b1);
        step(1'b1, 4'hC, 1'b0, '0, 1'b0);
        drain();
        step(1'b1, 4'h1, 1'b1, 4'h2, 1'b1);
        step(1'b1, 4'h1, 1'b1, 4'h2, 1'b1);
        drain();

        // Asynchronous reset pulse between edges with two words queued.
        step(1'b1, 4'h6, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 4'hE, 1'b0);
        l0_valid = 1'b1; l1_valid = 1'b1;
        rst_n = 1'b0;
        #2;
        check("arst_r_valid", 32'(r_valid), 32'd0);
        check("arst_r_data", 32'({r_src, r_data}), 32'd0);
        check("arst_l0_ready", 32'(l0_ready), 32'd0);
        check("arst_l1_ready", 32'(l1_ready), 32'd0);
        sb.delete();
        m_cnt  = 0;
        m_last = 1'b1;
        #1;
        rst_n = 1'b1;
        step(1'b1, 4'hC, 1'b1, 4'hD, 1'b1);
        check("arst_first_grant_l0", 32'(acc0), 32'd1);
        drain();

        // Randomized producers that hold each word until it is accepted.
        p0 = 1'b0; p1 = 1'b0; pd0 = '0; pd1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && ($urandom_range(0, 2) != 0)) begin p0 = 1'b1; pd0 = WIDTH'($urandom); end
            if (!p1 && ($urandom_range(0, 2) != 0)) begin p1 = 1'b1; pd1 = WIDTH'($urandom); end
            step(p0, pd0, p1, pd1, 1'($urandom_range(0, 1)));
            if (acc0) p0 = 1'b0;
            if (acc1) p1 = 1'b0;
        end
        drain();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
